// File: rtl/mem_load_ctrl.sv
// mem_load_ctrl: MEM-stage load controller sitting between the pipeline and
// the data cache. It validates alignment, issues one cache read, waits for the
// data (with a timeout) and returns the sign/zero-extended load result.
//
// Optional feature: define MEM_LOAD_FLUSH_EN to honour the flush input
// (drops/drains the in-flight load). Without it flush is ignored and the
// DRAIN state is unreachable.
//
// Ports
//   clk, resetn                 clock, synchronous active-low reset
//   ld_valid/ld_op/ld_addr      load request from MEM (sampled in IDLE only)
//   flush                       pipeline flush (MEM_LOAD_FLUSH_EN builds)
//   data_req/data_addr/data_size  cache request (word-aligned address)
//   data_addr_ok/data_data_ok/data_rdata  cache handshake and read data
//   ld_result, ld_done          extended result, one-cycle completion pulse
//   ld_adel, ld_err             misalignment / timeout pulses
//   stall                       pipeline hold
//   dbg_state                   current FSM state (IDLE=0 REQ=1 WAIT=2 DONE=3 DRAIN=4)
//
// Handshake: data_req is held high with data_addr/data_size stable until a
// cycle where data_addr_ok=1; the request is then retired. data_data_ok is a
// single-cycle strobe qualifying data_rdata and is only honoured in WAIT/DRAIN.
module mem_load_ctrl #(
    parameter int WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ld_valid,
    input  logic [2:0]  ld_op,
    input  logic [31:0] ld_addr,
    input  logic        flush,
    output logic        data_req,
    output logic [31:0] data_addr,
    output logic [1:0]  data_size,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [31:0] ld_result,
    output logic        ld_done,
    output logic        ld_adel,
    output logic        ld_err,
    output logic        stall,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

`ifdef MEM_LOAD_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    localparam logic [7:0] CNT_LAST = 8'(WAIT_LIMIT - 1);

    state_t      state_q, state_d;
    logic        data_req_q, data_req_d;
    logic [31:0] data_addr_q, data_addr_d;
    logic [1:0]  data_size_q, data_size_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  lane_q, lane_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;
    logic        done_q, done_d;
    logic        adel_q, adel_d;
    logic        err_q, err_d;

    logic        flush_eff;
    logic        misaligned;
    logic [1:0]  req_size;
    logic [31:0] shifted;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] ext_data;

    assign flush_eff = flush & FLUSH_EN;

    // Alignment rules and cache size for the incoming request.
    always_comb begin
        misaligned = 1'b0;
        req_size   = 2'd2;
        case (ld_op)
            3'd0, 3'd1: begin misaligned = 1'b0;               req_size = 2'd0; end
            3'd2, 3'd3: begin misaligned = ld_addr[0];         req_size = 2'd1; end
            default:    begin misaligned = |ld_addr[1:0];      req_size = 2'd2; end
        endcase
    end

    // Little-endian lane selection and extension of the returned word.
    always_comb begin
        shifted  = data_rdata >> {lane_q, 3'b000};
        sel_byte = shifted[7:0];
        sel_half = lane_q[1] ? data_rdata[31:16] : data_rdata[15:0];
        case (op_q)
            3'd0:    ext_data = {{24{sel_byte[7]}}, sel_byte};
            3'd1:    ext_data = {24'b0, sel_byte};
            3'd2:    ext_data = {{16{sel_half[15]}}, sel_half};
            3'd3:    ext_data = {16'b0, sel_half};
            default: ext_data = data_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        data_req_d  = data_req_q;
        data_addr_d = data_addr_q;
        data_size_d = data_size_q;
        op_d        = op_q;
        lane_d      = lane_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        done_d      = 1'b0;
        adel_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ld_valid && !flush_eff) begin
                    if (misaligned) begin
                        adel_d = 1'b1;
                    end else begin
                        op_d        = ld_op;
                        lane_d      = ld_addr[1:0];
                        data_addr_d = {ld_addr[31:2], 2'b00};
                        data_size_d = req_size;
                        data_req_d  = 1'b1;
                        state_d     = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (flush_eff) begin
                    data_req_d = 1'b0;
                    state_d    = S_IDLE;
                end else if (data_addr_ok) begin
                    data_req_d = 1'b0;
                    cnt_d      = 8'd0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (data_data_ok) begin
                    if (flush_eff) begin
                        state_d = S_IDLE;
                    end else begin
                        result_d = ext_data;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // A flushed load that times out is simply abandoned.
                    if (!flush_eff) begin
                        err_d    = 1'b1;
                        done_d   = 1'b1;
                        result_d = 32'd0;
                    end
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (flush_eff) state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                // Swallow the outstanding response so it cannot be mistaken
                // for the next load's data; the timeout still bounds the wait.
                if (data_data_ok || cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            data_req_q  <= 1'b0;
            data_addr_q <= 32'd0;
            data_size_q <= 2'd0;
            op_q        <= 3'd0;
            lane_q      <= 2'd0;
            cnt_q       <= 8'd0;
            result_q    <= 32'd0;
            done_q      <= 1'b0;
            adel_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_req_q  <= data_req_d;
            data_addr_q <= data_addr_d;
            data_size_q <= data_size_d;
            op_q        <= op_d;
            lane_q      <= lane_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            done_q      <= done_d;
            adel_q      <= adel_d;
            err_q       <= err_d;
        end
    end

    assign data_req  = data_req_q;
    assign data_addr = data_addr_q;
    assign data_size = data_size_q;
    assign ld_result = result_q;
    // A flush arriving in DONE kills the completion that is being presented.
    assign ld_done   = done_q & ~((state_q == S_DONE) & flush_eff);
    assign ld_adel   = adel_q;
    assign ld_err    = err_q;
    assign dbg_state = state_q;

    // Stall is partly combinational: a freshly presented aligned load must hold
    // the pipeline in the very cycle it is accepted.
    assign stall = resetn & ((state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_DRAIN) ||
                   ((state_q == S_IDLE) && ld_valid && !misaligned && !flush_eff));

endmodule

// File: tb/tb_mem_load_ctrl.sv
module tb_mem_load_ctrl;

  logic        clk;
  logic        resetn;
  logic        ld_valid;
  logic [2:0]  ld_op;
  logic [31:0] ld_addr;
  logic        flush;
  logic        data_req;
  logic [31:0] data_addr;
  logic [1:0]  data_size;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] ld_result;
  logic        ld_done;
  logic        ld_adel;
  logic        ld_err;
  logic        stall;
  logic [2:0]  dbg_state;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_result;

  mem_load_ctrl #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .resetn(resetn), .ld_valid(ld_valid), .ld_op(ld_op),
    .ld_addr(ld_addr), .flush(flush), .data_req(data_req),
    .data_addr(data_addr), .data_size(data_size),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .ld_result(ld_result), .ld_done(ld_done),
    .ld_adel(ld_adel), .ld_err(ld_err), .stall(stall), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic bit ref_misaligned(input logic [2:0] op, input logic [31:0] a);
    if (op == 3'd0 || op == 3'd1) return 1'b0;
    if (op == 3'd2 || op == 3'd3) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic logic [1:0] ref_size(input logic [2:0] op);
    if (op <= 3'd1) return 2'd0;
    if (op <= 3'd3) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd / (32'd1 << (8 * (a % 4)))) % 256;
    h = (rd / (32'd1 << (16 * ((a / 2) % 2)))) % 65536;
    case (op)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd1:    return b;
      3'd2:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd3:    return h;
      default: return rd;
    endcase
  endfunction

  // ---------------- driver: one aligned load, checked end to end ----------------
  // Called just after a negedge with the DUT in IDLE; returns just after the
  // negedge of the IDLE cycle following DONE.
  task automatic run_load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] rd,
                          input int ack_dly, input int data_dly);
    int t0;
    logic [31:0] exp_addr;
    exp_q.push_back(ref_result(op, a, rd));
    exp_addr = a - (a % 4);
    t0 = cyc;
    ld_valid = 1'b1; ld_op = op; ld_addr = a;
    #1;
    vec_cnt++;
    if (stall !== 1'b1) begin err_cnt++; $display("FAIL accept_stall: got %b want 1", stall); end
    @(negedge clk);
    ld_valid = 1'b0; ld_op = 3'($urandom); ld_addr = $urandom;
    vec_cnt++;
    if (data_req !== 1'b1 || data_addr !== exp_addr || data_size !== ref_size(op)) begin
      err_cnt++;
      $display("FAIL req_fields: got req=%b addr=%h size=%0d want 1 %h %0d",
               data_req, data_addr, data_size, exp_addr, ref_size(op));
    end
    for (int i = 0; i < ack_dly; i++) begin
      data_addr_ok = 1'b0; data_data_ok = 1'($urandom); data_rdata = $urandom;
      @(negedge clk);
      vec_cnt++;
      if (data_req !== 1'b1 || data_addr !== exp_addr) begin
        err_cnt++;
        $display("FAIL req_hold: got req=%b addr=%h want 1 %h", data_req, data_addr, exp_addr);
      end
    end
    data_addr_ok = 1'b1; data_data_ok = 1'($urandom); data_rdata = $urandom;
    @(negedge clk);
    data_addr_ok = 1'b0;
    vec_cnt++;
    if (data_req !== 1'b0 || stall !== 1'b1) begin
      err_cnt++; $display("FAIL wait_entry: got req=%b stall=%b want 0 1", data_req, stall);
    end
    for (int i = 0; i < data_dly; i++) begin
      data_data_ok = 1'b0; data_rdata = $urandom;
      @(negedge clk);
      vec_cnt++;
      if (ld_done !== 1'b0) begin err_cnt++; $display("FAIL early_done: got %b want 0", ld_done); end
    end
    data_data_ok = 1'b1; data_rdata = rd;
    @(negedge clk);
    data_data_ok = 1'($urandom); data_rdata = $urandom;
    last_result = exp_q.pop_front();
    vec_cnt++;
    if (ld_done !== 1'b1 || ld_err !== 1'b0 || ld_result !== last_result || stall !== 1'b0 ||
        (cyc - t0) != 3 + ack_dly + data_dly) begin
      err_cnt++;
      $display("FAIL done: got done=%b err=%b res=%h stall=%b lat=%0d want 1 0 %h 0 %0d",
               ld_done, ld_err, ld_result, stall, cyc - t0, last_result, 3 + ack_dly + data_dly);
    end
    @(negedge clk);
    data_data_ok = 1'b0;
    vec_cnt++;
    if (ld_done !== 1'b0 || ld_result !== last_result || dbg_state !== 3'd0) begin
      err_cnt++;
      $display("FAIL after_done: got done=%b res=%h st=%0d want 0 %h 0", ld_done, ld_result,
               dbg_state, last_result);
    end
  endtask

  // Drives an aligned LW up to its first WAIT cycle (called after a negedge).
  task automatic enter_wait();
    ld_valid = 1'b1; ld_op = 3'd4; ld_addr = 32'h2000;
    @(negedge clk);
    ld_valid = 1'b0; data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    resetn = 1'b0; ld_valid = 1'b0; ld_op = 3'd0; ld_addr = 32'd0; flush = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if ({data_req, data_addr, data_size, ld_result, ld_done, ld_adel, ld_err, stall} !== '0 ||
        dbg_state !== 3'd0) begin
      err_cnt++;
      $display("FAIL reset_values: got req=%b addr=%h size=%0d res=%h done=%b adel=%b err=%b stall=%b st=%0d want all 0",
               data_req, data_addr, data_size, ld_result, ld_done, ld_adel, ld_err, stall, dbg_state);
    end
  endtask

  task automatic test_directed();
    run_load(3'd1, 32'h1003, 32'h80FF_1234, 0, 0);
    vec_cnt++;
    if (ld_result !== 32'h0000_0080) begin err_cnt++; $display("FAIL lbu_const: got %h want 00000080", ld_result); end
    run_load(3'd0, 32'h1003, 32'h80FF_1234, 0, 0);
    vec_cnt++;
    if (ld_result !== 32'hFFFF_FF80) begin err_cnt++; $display("FAIL lb_const: got %h want ffffff80", ld_result); end
    run_load(3'd2, 32'h1002, 32'h80FF_1234, 0, 0);
    vec_cnt++;
    if (ld_result !== 32'hFFFF_80FF) begin err_cnt++; $display("FAIL lh_const: got %h want ffff80ff", ld_result); end
    run_load(3'd3, 32'h1002, 32'h80FF_1234, 0, 0);
    vec_cnt++;
    if (ld_result !== 32'h0000_80FF) begin err_cnt++; $display("FAIL lhu_const: got %h want 000080ff", ld_result); end
    run_load(3'd4, 32'h1004, 32'hDEAD_BEEF, 1, 2);
  endtask

  task automatic test_misaligned(input logic [2:0] op, input logic [31:0] a);
    int seen_req = 0;
    ld_valid = 1'b1; ld_op = op; ld_addr = a;
    #1;
    vec_cnt++;
    if (stall !== 1'b0) begin err_cnt++; $display("FAIL adel_stall: got %b want 0", stall); end
    @(negedge clk);
    ld_valid = 1'b0;
    if (data_req) seen_req++;
    vec_cnt++;
    if (ld_adel !== 1'b1 || dbg_state !== 3'd0 || stall !== 1'b0) begin
      err_cnt++;
      $display("FAIL adel_pulse: got adel=%b st=%0d stall=%b want 1 0 0", ld_adel, dbg_state, stall);
    end
    repeat (2) begin
      @(negedge clk);
      if (data_req) seen_req++;
    end
    vec_cnt++;
    if (ld_adel !== 1'b0 || seen_req != 0 || ld_done !== 1'b0) begin
      err_cnt++;
      $display("FAIL adel_after: got adel=%b req_cycles=%0d done=%b want 0 0 0", ld_adel, seen_req, ld_done);
    end
  endtask

  task automatic test_timeout();
    enter_wait();
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (ld_done !== 1'b0 || ld_err !== 1'b0 || stall !== 1'b1) begin
        err_cnt++;
        $display("FAIL timeout_wait%0d: got done=%b err=%b stall=%b want 0 0 1", i, ld_done, ld_err, stall);
      end
      @(negedge clk);
    end
    vec_cnt++;
    if (ld_err !== 1'b1 || ld_done !== 1'b1 || ld_result !== 32'd0 || dbg_state !== 3'd0) begin
      err_cnt++;
      $display("FAIL timeout: got err=%b done=%b res=%h st=%0d want 1 1 0 0", ld_err, ld_done, ld_result, dbg_state);
    end
    @(negedge clk);
    vec_cnt++;
    if (ld_err !== 1'b0 || ld_done !== 1'b0) begin
      err_cnt++; $display("FAIL timeout_pulse: got err=%b done=%b want 0 0", ld_err, ld_done);
    end
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [31:0] a;
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & (op <= 3'd3 && op >= 3'd2 ? 32'hFFFF_FFFE :
                                              (op <= 3'd1 ? 32'hFFFF_FFFF : 32'hFFFF_FFFC));
      if (ref_misaligned(op, a)) test_misaligned(op, a);
      else run_load(op, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++)
      run_load(3'(n), 32'h3000 + 32'(2 * n), $urandom, 0, 0);
  endtask

  task automatic test_reset_mid();
    enter_wait();
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    data_data_ok = 1'b0;
    repeat (2) begin
      vec_cnt++;
      if ({data_req, data_addr, data_size, ld_result, ld_done, ld_adel, ld_err, stall} !== '0 ||
          dbg_state !== 3'd0) begin
        err_cnt++;
        $display("FAIL reset_mid: got req=%b addr=%h res=%h done=%b stall=%b st=%0d want all 0",
                 data_req, data_addr, ld_result, ld_done, stall, dbg_state);
      end
      @(negedge clk);
    end
  endtask

`ifdef MEM_LOAD_FLUSH_EN
  task automatic test_flush();
    int done_seen = 0;
    enter_wait();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    vec_cnt++;
    if (dbg_state !== 3'd4 || stall !== 1'b1) begin
      err_cnt++; $display("FAIL drain_entry: got st=%0d stall=%b want 4 1", dbg_state, stall);
    end
    repeat (2) begin
      if (ld_done) done_seen++;
      @(negedge clk);
    end
    data_data_ok = 1'b1;
    @(negedge clk);
    data_data_ok = 1'b0;
    if (ld_done) done_seen++;
    vec_cnt++;
    if (dbg_state !== 3'd0 || done_seen != 0 || stall !== 1'b0) begin
      err_cnt++;
      $display("FAIL drain_exit: got st=%0d dones=%0d stall=%b want 0 0 0", dbg_state, done_seen, stall);
    end
    run_load(3'd4, 32'h4000, 32'h1234_5678, 0, 1);
  endtask
`else
  task automatic test_flush();
    // Flush must have no effect: a load flushed mid-flight still completes.
    logic [31:0] rd;
    rd = $urandom;
    enter_wait();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; data_data_ok = 1'b1; data_rdata = rd;
    @(negedge clk);
    data_data_ok = 1'b0;
    vec_cnt++;
    if (ld_done !== 1'b1 || ld_result !== rd || dbg_state !== 3'd3) begin
      err_cnt++;
      $display("FAIL flush_ignored: got done=%b res=%h st=%0d want 1 %h 3", ld_done, ld_result, dbg_state, rd);
    end
    @(negedge clk);
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_misaligned(3'd4, 32'h1002);
    test_misaligned(3'd3, 32'h1001);
    test_timeout();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule
